// File: rtl/hog_pkg.sv
// Shared HOG pipeline constants and the histogram bin-slice offset helper.
package hog_pkg;

    localparam int HOG_NUM_BINS   = 9;
    localparam int HOG_DATA_WIDTH = 8;
    localparam int HOG_BIN_WIDTH  = 11;
    localparam int HOG_CELL_W     = 8;

    // Bit offset of bin k inside a flat histogram bus of bw-bit bins.
    function automatic int unsigned bin_offset(input int unsigned k, input int unsigned bw);
        return k * bw;
    endfunction

endpackage

// File: rtl/hist_bin_update.sv
// Combinational histogram vote: adds one pixel's magnitude to its bin(s) with
// per-bin saturation. Build macro ROW_HIST_INTERP_EN enables bilinear vote
// splitting between bin_index and (bin_index+1) mod NUM_BINS.
module hist_bin_update
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH = HOG_DATA_WIDTH,
    parameter int BIN_WIDTH  = HOG_BIN_WIDTH,
    parameter int NUM_BINS   = HOG_NUM_BINS,
    parameter int FRAC_WIDTH = 4,
    parameter int IDX_WIDTH  = 4
) (
    input  logic [NUM_BINS*BIN_WIDTH-1:0] i_acc,
    input  logic [IDX_WIDTH-1:0]          i_bin_index,
    input  logic [DATA_WIDTH-1:0]         i_magnitude,
    input  logic [FRAC_WIDTH-1:0]         i_frac,
    output logic [NUM_BINS*BIN_WIDTH-1:0] o_acc_next,
    output logic                          o_sat
);

    localparam int SUM_W = ((BIN_WIDTH > DATA_WIDTH) ? BIN_WIDTH : DATA_WIDTH) + 1;
    localparam logic [SUM_W-1:0] BIN_MAX = SUM_W'({BIN_WIDTH{1'b1}});

    logic [DATA_WIDTH-1:0] w_lo;
    logic [SUM_W-1:0]      w_add;
    logic [SUM_W-1:0]      w_sum;

`ifdef ROW_HIST_INTERP_EN
    localparam int PROD_W = DATA_WIDTH + FRAC_WIDTH + 1;

    logic [PROD_W-1:0]     w_prod;
    logic [DATA_WIDTH-1:0] w_hi;
    logic [IDX_WIDTH-1:0]  w_hi_idx;
    logic                  w_in_range;

    // Split magnitude into the primary-bin share and the remainder for the next bin
    always_comb begin
        w_prod     = PROD_W'(i_magnitude) * ((PROD_W'(1) << FRAC_WIDTH) - PROD_W'(i_frac));
        w_lo       = DATA_WIDTH'(w_prod >> FRAC_WIDTH);
        w_hi       = i_magnitude - w_lo;
        w_in_range = ({1'b0, i_bin_index} < (IDX_WIDTH+1)'(NUM_BINS));
        w_hi_idx   = (i_bin_index == IDX_WIDTH'(NUM_BINS-1)) ? '0 : i_bin_index + 1'b1;
    end
`else
    logic w_unused_frac;

    // Whole magnitude votes into the primary bin; frac has no effect
    always_comb begin
        w_lo          = i_magnitude;
        w_unused_frac = ^i_frac;
    end
`endif

    // Per-bin saturating add; an out-of-range bin_index matches no bin
    always_comb begin
        o_acc_next = i_acc;
        o_sat      = 1'b0;
        w_add      = '0;
        w_sum      = '0;
        for (int unsigned k = 0; k < NUM_BINS; k++) begin
            w_add = '0;
            if (i_bin_index == IDX_WIDTH'(k))
                w_add = SUM_W'(w_lo);
`ifdef ROW_HIST_INTERP_EN
            if (w_in_range && (w_hi_idx == IDX_WIDTH'(k)))
                w_add = w_add + SUM_W'(w_hi);
`endif
            w_sum = SUM_W'(i_acc[bin_offset(k, BIN_WIDTH) +: BIN_WIDTH]) + w_add;
            if (w_sum > BIN_MAX) begin
                o_acc_next[bin_offset(k, BIN_WIDTH) +: BIN_WIDTH] = '1;
                o_sat = 1'b1;
            end else begin
                o_acc_next[bin_offset(k, BIN_WIDTH) +: BIN_WIDTH] = BIN_WIDTH'(w_sum);
            end
        end
    end

endmodule

// File: rtl/row_histogram_gen.sv
// Per cell-row orientation histogram accumulator with double-buffered
// accumulator/output registers and valid/ready handshakes on both sides.
// Build macro ROW_HIST_INTERP_EN enables bilinear bin interpolation.
module row_histogram_gen
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH      = HOG_DATA_WIDTH,
    parameter int BIN_WIDTH       = HOG_BIN_WIDTH,
    parameter int NUM_BINS        = HOG_NUM_BINS,
    parameter int CELL_W          = HOG_CELL_W,
    parameter int FRAC_WIDTH      = 4,
    parameter int IDX_WIDTH       = 4,
    parameter int HISTOGRAM_WIDTH = BIN_WIDTH * NUM_BINS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      magnitude,
    input  logic [IDX_WIDTH-1:0]       bin_index,
    input  logic [FRAC_WIDTH-1:0]      frac,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HISTOGRAM_WIDTH-1:0] row_histogram,
    output logic                       out_sat
);

    localparam int CNT_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;

    logic [HISTOGRAM_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_acc_sat;
    logic [HISTOGRAM_WIDTH-1:0] r_out;
    logic                       r_out_sat;
    logic                       r_out_full;
    logic                       r_hold;

    logic [HISTOGRAM_WIDTH-1:0] w_acc_next;
    logic                       w_sat;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_drain;
    logic                       w_xfer_last;
    logic                       w_xfer_hold;

    hist_bin_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_BINS   (NUM_BINS),
        .FRAC_WIDTH (FRAC_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_update (
        .i_acc       (r_acc),
        .i_bin_index (bin_index),
        .i_magnitude (magnitude),
        .i_frac      (frac),
        .o_acc_next  (w_acc_next),
        .o_sat       (w_sat)
    );

    // Handshake decode: accept, row completion, drain and the two transfer paths
    always_comb begin
        w_accept    = in_valid && !r_hold;
        w_last      = w_accept && (r_cnt == CNT_W'(CELL_W-1));
        w_drain     = out_ready && r_out_full;
        w_xfer_last = w_last && (!r_out_full || out_ready);
        w_xfer_hold = r_hold && w_drain;
    end

    // Accumulator, pixel counter and sticky saturation for the row in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_xfer_last || w_xfer_hold) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_accept) begin
            r_acc     <= w_acc_next;
            r_acc_sat <= r_acc_sat | w_sat;
            r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Hold: a completed row is parked in the accumulator until the output frees up
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_hold <= 1'b0;
        else if (w_last && !w_xfer_last)
            r_hold <= 1'b1;
        else if (w_xfer_hold)
            r_hold <= 1'b0;
    end

    // Output register: loads on either transfer path, empties on a plain drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= '0;
            r_out_sat  <= 1'b0;
            r_out_full <= 1'b0;
        end else if (w_xfer_last) begin
            r_out      <= w_acc_next;
            r_out_sat  <= r_acc_sat | w_sat;
            r_out_full <= 1'b1;
        end else if (w_xfer_hold) begin
            r_out      <= r_acc;
            r_out_sat  <= r_acc_sat;
            r_out_full <= 1'b1;
        end else if (w_drain) begin
            r_out_full <= 1'b0;
        end
    end

    assign in_ready      = !r_hold;
    assign out_valid     = r_out_full;
    assign row_histogram = r_out;
    assign out_sat       = r_out_sat;

endmodule

// File: tb/tb_row_histogram_gen.sv
// Directed bench for row_histogram_gen: default instance plus a 9-bit-bin
// instance sharing stimulus, a row table streamed back-to-back, and hand
// sequences for backpressure/hold, same-cycle drain+transfer and mid-row reset.
module tb_row_histogram_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  magnitude;
    logic [3:0]  bin_index;
    logic [3:0]  frac;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_sat;
    logic [98:0] row_histogram;
    logic        in_ready9, out_valid9, out_sat9;
    logic [80:0] row_histogram9;

    int unsigned checks = 0;
    int unsigned errors = 0;

    row_histogram_gen dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .magnitude(magnitude), .bin_index(bin_index), .frac(frac),
        .out_valid(out_valid), .out_ready(out_ready),
        .row_histogram(row_histogram), .out_sat(out_sat)
    );

    row_histogram_gen #(.BIN_WIDTH(9)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
        .magnitude(magnitude), .bin_index(bin_index), .frac(frac),
        .out_valid(out_valid9), .out_ready(out_ready),
        .row_histogram(row_histogram9), .out_sat(out_sat9)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][3:0]  bin;
        logic [7:0][7:0]  mag;
        logic [7:0][3:0]  frc;
        logic [8:0][10:0] exp;
        logic             exp_sat;
        logic [8:0][8:0]  exp9;
        logic             exp_sat9;
    } row_t;

    localparam int NROWS = 7;
    row_t tbl [NROWS];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill(input int r, input logic [3:0] b, input logic [7:0] m, input logic [3:0] f);
        tbl[r].bin = '0; tbl[r].mag = '0; tbl[r].frc = '0;
        tbl[r].exp = '0; tbl[r].exp9 = '0;
        tbl[r].exp_sat = 1'b0; tbl[r].exp_sat9 = 1'b0;
        for (int p = 0; p < 8; p++) begin
            tbl[r].bin[p] = b;
            tbl[r].mag[p] = m;
            tbl[r].frc[p] = f;
        end
    endtask

    // Present one pixel (in_ready must be high) and step to #1 after the edge.
    task automatic push(input logic [3:0] b, input logic [7:0] m, input logic [3:0] f);
        in_valid  = 1'b1;
        bin_index = b;
        magnitude = m;
        frac      = f;
        chk("in_ready_before_accept", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0][10:0] e;
        logic [8:0][10:0] ep;

        // Row table
        fill(0, 4'd3, 8'd10, 4'd0);
        tbl[0].exp[3] = 11'd80;  tbl[0].exp9[3] = 9'd80;
        fill(1, 4'd0, 8'd1, 4'd0);
        for (int p = 0; p < 8; p++) begin
            tbl[1].bin[p] = 4'(p);
            tbl[1].exp[p] = 11'd1;
            tbl[1].exp9[p] = 9'd1;
        end
        fill(2, 4'd8, 8'd255, 4'd0);
        tbl[2].exp[8] = 11'd2040; tbl[2].exp9[8] = 9'd511; tbl[2].exp_sat9 = 1'b1;
        fill(3, 4'd12, 8'd200, 4'd0);
        fill(4, 4'd0, 8'd255, 4'd0);
        tbl[4].exp[0] = 11'd2040; tbl[4].exp9[0] = 9'd511; tbl[4].exp_sat9 = 1'b1;
        fill(5, 4'd0, 8'd3, 4'd0);
        tbl[5].exp[0] = 11'd24;  tbl[5].exp9[0] = 9'd24;
        fill(6, 4'd8, 8'd16, 4'd4);
`ifdef ROW_HIST_INTERP_EN
        tbl[6].exp[8] = 11'd96;  tbl[6].exp[0] = 11'd32;
        tbl[6].exp9[8] = 9'd96;  tbl[6].exp9[0] = 9'd32;
`else
        tbl[6].exp[8] = 11'd128; tbl[6].exp9[8] = 9'd128;
`endif

        // Reset state
        rst = 1'b1; in_valid = 1'b0; magnitude = '0; bin_index = '0; frac = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  128'(in_ready),      128'(1'b1));
        chk("rst_out_valid", 128'(out_valid),     128'(1'b0));
        chk("rst_hist",      128'(row_histogram), 128'(0));
        chk("rst_out_sat",   128'(out_sat),       128'(1'b0));
        chk("rst_hist9",     128'(row_histogram9), 128'(0));
        rst = 1'b0;
        step();

        // Stream all table rows back-to-back with out_ready held high
        for (int r = 0; r < NROWS; r++) begin
            for (int p = 0; p < 8; p++)
                push(tbl[r].bin[p], tbl[r].mag[p], tbl[r].frc[p]);
            chk($sformatf("row%0d_valid", r), 128'(out_valid), 128'(1'b1));
            chk($sformatf("row%0d_hist", r),  128'(row_histogram), 128'(tbl[r].exp));
            chk($sformatf("row%0d_sat", r),   128'(out_sat), 128'(tbl[r].exp_sat));
            chk($sformatf("row%0d_hist9", r), 128'(row_histogram9), 128'(tbl[r].exp9));
            chk($sformatf("row%0d_sat9", r),  128'(out_sat9), 128'(tbl[r].exp_sat9));
        end
        in_valid = 1'b0;
        step();
        chk("drained_valid", 128'(out_valid), 128'(1'b0));

        // Backpressure: two rows with out_ready low, second row goes into hold
        out_ready = 1'b0;
        ep = '0; ep[1] = 11'd16;
        e  = '0; e[2]  = 11'd40;
        for (int p = 0; p < 8; p++) push(4'd1, 8'd2, 4'd0);
        chk("bp_first_valid", 128'(out_valid), 128'(1'b1));
        chk("bp_first_hist",  128'(row_histogram), 128'(ep));
        for (int p = 0; p < 8; p++) push(4'd2, 8'd5, 4'd0);
        chk("bp_hold_in_ready", 128'(in_ready), 128'(1'b0));
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_hold_in_ready_stays", 128'(in_ready), 128'(1'b0));
        chk("bp_hold_valid",  128'(out_valid), 128'(1'b1));
        chk("bp_hold_stable", 128'(row_histogram), 128'(ep));
        out_ready = 1'b1;
        step();
        chk("bp_release_valid",    128'(out_valid), 128'(1'b1));
        chk("bp_release_hist",     128'(row_histogram), 128'(e));
        chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));
        step();
        chk("bp_after_valid", 128'(out_valid), 128'(1'b0));

        // Drain and last-pixel transfer on the same edge
        out_ready = 1'b0;
        ep = '0; ep[4] = 11'd56;
        e  = '0; e[5]  = 11'd72;
        for (int p = 0; p < 8; p++) push(4'd4, 8'd7, 4'd0);
        for (int p = 0; p < 7; p++) push(4'd5, 8'd9, 4'd0);
        chk("same_pre_hist", 128'(row_histogram), 128'(ep));
        out_ready = 1'b1;
        push(4'd5, 8'd9, 4'd0);
        in_valid = 1'b0;
        chk("same_valid",    128'(out_valid), 128'(1'b1));
        chk("same_hist",     128'(row_histogram), 128'(e));
        chk("same_in_ready", 128'(in_ready), 128'(1'b1));
        step();
        chk("same_after_valid", 128'(out_valid), 128'(1'b0));

        // Reset mid-row discards partial data; the following row is clean
        for (int p = 0; p < 5; p++) push(4'd3, 8'd10, 4'd0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_hist",      128'(row_histogram), 128'(0));
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        e = '0; e[6] = 11'd160;
        for (int p = 0; p < 8; p++) push(4'd6, 8'd20, 4'd0);
        in_valid = 1'b0;
        chk("postrst_valid", 128'(out_valid), 128'(1'b1));
        chk("postrst_hist",  128'(row_histogram), 128'(e));
        chk("postrst_sat",   128'(out_sat), 128'(1'b0));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
